// File: rtl/mem_arbiter_rr.sv
// Shared single-port data memory arbiter for a C-core array: one round-robin memory grant per
// cycle with 1-cycle read return, plus an NL-entry mutex table with owner tracking.
module mem_arbiter_rr #(
  parameter int unsigned C  = 8,
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16,
  parameter int unsigned NL = 16,
  parameter int unsigned LW = $clog2(NL),
  parameter int unsigned CW = $clog2(C)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [C-1:0]    req,
  input  logic [C-1:0]    we,
  input  logic [C*AW-1:0] adr,
  input  logic [C*DW-1:0] wdat,
  output logic [C-1:0]    gnt,
  output logic [C-1:0]    rvalid,
  output logic [DW-1:0]   rdat,
  output logic [AW-1:0]   mem_adr,
  output logic [DW-1:0]   mem_wdat,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_rdat,
  input  logic [C-1:0]    lock_req,
  input  logic [C-1:0]    unlock_req,
  input  logic [C*LW-1:0] lock_id,
  output logic [C-1:0]    lock_ac,
  output logic [C-1:0]    lock_err,
  output logic [NL-1:0]   lock_state
);

  // Returns {found, index} of the first set bit of vec at or after ptr, wrapping modulo C.
  function automatic logic [CW:0] rr_pick(input logic [C-1:0] vec, input logic [CW-1:0] ptr);
    logic [CW:0] res;
    int unsigned idx;
    res = '0;
    for (int unsigned off = 0; off < C; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= C) idx = idx - C;
      if (!res[CW] && vec[idx[CW-1:0]]) res = {1'b1, idx[CW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] inc_mod(input logic [CW-1:0] v);
    return (32'(v) == C - 1) ? '0 : v + 1'b1;
  endfunction

  // Memory arbitration state
  logic [CW-1:0] rr_mem_q, rr_mem_d;
  logic          rd_pend_q, rd_pend_d;
  logic [CW-1:0] rd_id_q, rd_id_d;

  // Lock table state
  logic [CW-1:0]         rr_lock_q, rr_lock_d;
  logic [NL-1:0]         held_q, held_d;
  logic [NL-1:0][CW-1:0] owner_q, owner_d;

  logic [CW:0]   mem_pick;
  logic          mem_found;
  logic [CW-1:0] mem_win;

  assign mem_pick  = rr_pick(req, rr_mem_q);
  assign mem_found = mem_pick[CW];
  assign mem_win   = mem_pick[CW-1:0];

  always_comb begin
    gnt       = '0;
    mem_adr   = '0;
    mem_wdat  = '0;
    mem_we    = 1'b0;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    rr_mem_d  = rr_mem_q;
    if (mem_found && !reset) begin
      gnt[mem_win] = 1'b1;
      mem_adr      = adr[mem_win*AW +: AW];
      mem_wdat     = wdat[mem_win*DW +: DW];
      mem_we       = we[mem_win];
      rd_pend_d    = ~we[mem_win];
      rd_id_d      = mem_win;
      rr_mem_d     = inc_mod(mem_win);
    end
  end

  // Read data is broadcast; rvalid tells which core the returning word belongs to.
  always_comb begin
    rvalid = '0;
    if (rd_pend_q && !reset) rvalid[rd_id_q] = 1'b1;
  end

  assign rdat = mem_rdat;

  logic [LW-1:0] cur_id;
  logic [C-1:0]  unlock_ack;
  logic [C-1:0]  unlock_bad;
  logic [C-1:0]  lock_cand;
  logic [NL-1:0] unlock_clr;

  // Unlocks always ack; a core unlocking this cycle is not a lock candidate.
  always_comb begin
    cur_id     = '0;
    unlock_ack = '0;
    unlock_bad = '0;
    lock_cand  = '0;
    unlock_clr = '0;
    for (int unsigned i = 0; i < C; i++) begin
      cur_id = lock_id[i*LW +: LW];
      if (unlock_req[i]) begin
        unlock_ack[i] = 1'b1;
        if (held_q[cur_id] && owner_q[cur_id] == CW'(i)) begin
          unlock_clr[cur_id] = 1'b1;
        end else begin
          unlock_bad[i] = 1'b1;
        end
      end else if (lock_req[i] && !held_q[cur_id]) begin
        lock_cand[i] = 1'b1;
      end
    end
  end

  logic [CW:0]   lock_pick;
  logic          lock_found;
  logic [CW-1:0] lock_win;
  logic [LW-1:0] win_id;
  logic [C-1:0]  lock_win_oh;

  assign lock_pick  = rr_pick(lock_cand, rr_lock_q);
  assign lock_found = lock_pick[CW];
  assign lock_win   = lock_pick[CW-1:0];

  // A winning lock targets a free id while a legal unlock targets a held one, so they never collide.
  always_comb begin
    held_d      = held_q & ~unlock_clr;
    owner_d     = owner_q;
    rr_lock_d   = rr_lock_q;
    lock_win_oh = '0;
    win_id      = lock_id[lock_win*LW +: LW];
    if (lock_found) begin
      lock_win_oh[lock_win] = 1'b1;
      held_d[win_id]        = 1'b1;
      owner_d[win_id]       = lock_win;
      rr_lock_d             = inc_mod(lock_win);
    end
  end

  always_comb begin
    lock_ac    = '0;
    lock_err   = '0;
    lock_state = '0;
    if (!reset) begin
      lock_ac    = unlock_ack | lock_win_oh;
      lock_err   = unlock_bad;
      lock_state = held_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_mem_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
      rr_lock_q <= '0;
      held_q    <= '0;
      owner_q   <= '0;
    end else begin
      rr_mem_q  <= rr_mem_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      rr_lock_q <= rr_lock_d;
      held_q    <= held_d;
      owner_q   <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed vector table, hand-written multi-cycle sequences and a
// randomized run checked against a behavioural model of the arbiter and mutex rules.
module tb_mem_arbiter_rr;

  localparam int C  = 8;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NL = 16;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [C-1:0]    req = '0;
  logic [C-1:0]    we = '0;
  logic [C*AW-1:0] adr = '0;
  logic [C*DW-1:0] wdat = '0;
  logic [C-1:0]    gnt;
  logic [C-1:0]    rvalid;
  logic [DW-1:0]   rdat;
  logic [AW-1:0]   mem_adr;
  logic [DW-1:0]   mem_wdat;
  logic            mem_we;
  logic [DW-1:0]   mem_rdat;
  logic [C-1:0]    lock_req = '0;
  logic [C-1:0]    unlock_req = '0;
  logic [C*LW-1:0] lock_id = '0;
  logic [C-1:0]    lock_ac;
  logic [C-1:0]    lock_err;
  logic [NL-1:0]   lock_state;

  mem_arbiter_rr #(.C(C), .AW(AW), .DW(DW), .NL(NL), .LW(LW), .CW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .adr        (adr),
    .wdat       (wdat),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdat       (rdat),
    .mem_adr    (mem_adr),
    .mem_wdat   (mem_wdat),
    .mem_we     (mem_we),
    .mem_rdat   (mem_rdat),
    .lock_req   (lock_req),
    .unlock_req (unlock_req),
    .lock_id    (lock_id),
    .lock_ac    (lock_ac),
    .lock_err   (lock_err),
    .lock_state (lock_state)
  );

  always #5 clk = ~clk;

  // Memory macro: 256 words, 1-cycle read latency, initial contents A000+addr.
  logic [DW-1:0] tb_mem [256];
  logic          mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < 256; a++) tb_mem[a] <= 16'hA000 + 16'(a);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      tb_mem[mem_adr[7:0]] <= mem_wdat;
    end
    mem_rdat <= tb_mem[mem_adr[7:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            rst;
    logic [C-1:0]    req;
    logic [C-1:0]    we;
    logic [C-1:0]    lreq;
    logic [C-1:0]    ureq;
    logic [C*LW-1:0] lid;
    logic [C-1:0]    gnt;
    logic [C-1:0]    rv;
    logic            mwe;
    logic [DW-1:0]   rdat;
    logic [C-1:0]    ac;
    logic [C-1:0]    err;
    logic [NL-1:0]   st;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [C-1:0] rq, w, lr, ur,
                              input logic [C*LW-1:0] li, input logic [C-1:0] g, rv,
                              input logic mw, input logic [DW-1:0] rd,
                              input logic [C-1:0] ac, er, input logic [NL-1:0] st);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = w; v.lreq = lr; v.ureq = ur; v.lid = li;
    v.gnt = g; v.rv = rv; v.mwe = mw; v.rdat = rd; v.ac = ac; v.err = er; v.st = st;
    return v;
  endfunction

  // All cores on id 5 except the two given (core, id) overrides.
  function automatic logic [C*LW-1:0] mkid(input int c0, input int i0, input int c1, input int i1);
    logic [C*LW-1:0] r;
    r = {C{4'd5}};
    r[c0*LW +: LW] = LW'(i0);
    r[c1*LW +: LW] = LW'(i1);
    return r;
  endfunction

  task automatic run_table();
    vec_t tbl[$];
    logic [C*LW-1:0] l5;
    logic [DW-1:0] ew;
    l5 = mkid(0, 5, 0, 5);
    for (int i = 0; i < C; i++) begin
      adr[i*AW +: AW]  = 16'h0010;
      wdat[i*DW +: DW] = 16'hBEE9 + 16'(i);
    end
    //           rst req    we     lreq   ureq   lid              gnt    rv     mwe  rdat      ac     err    st
    tbl.push_back(mk(1, 8'hFF, 8'hFF, 8'hFF, 8'h00, l5,              8'h00, 8'h00, 0, 16'h0,    8'h00, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'hFF, 8'hFF, 8'hFF, 8'h00, l5,              8'h00, 8'h00, 0, 16'h0,    8'h00, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 8'h44, 8'h40, 8'h0A, 8'h00, l5,              8'h04, 8'h00, 0, 16'h0,    8'h02, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 8'h40, 8'h40, 8'h08, 8'h00, l5,              8'h40, 8'h04, 1, 16'hA010, 8'h00, 8'h00, 16'h0020));
    tbl.push_back(mk(0, 8'h01, 8'h00, 8'h08, 8'h02, l5,              8'h01, 8'h00, 0, 16'h0,    8'h02, 8'h00, 16'h0020));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h08, 8'h00, l5,              8'h00, 8'h01, 0, 16'hBEEF, 8'h08, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 8'h10, l5,              8'h00, 8'h00, 0, 16'h0,    8'h10, 8'h10, 16'h0020));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 8'h10, mkid(4, 9, 4, 9), 8'h00, 8'h00, 0, 16'h0,    8'h10, 8'h10, 16'h0020));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h01, 8'h08, l5,              8'h00, 8'h00, 0, 16'h0,    8'h08, 8'h00, 16'h0020));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h01, 8'h00, l5,              8'h00, 8'h00, 0, 16'h0,    8'h01, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h01, 8'h01, l5,              8'h00, 8'h00, 0, 16'h0,    8'h01, 8'h00, 16'h0020));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h24, 8'h00, mkid(2, 7, 5, 9), 8'h00, 8'h00, 0, 16'h0,    8'h04, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h20, 8'h00, mkid(2, 7, 5, 9), 8'h00, 8'h00, 0, 16'h0,    8'h20, 8'h00, 16'h0080));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 8'h24, mkid(2, 7, 5, 9), 8'h00, 8'h00, 0, 16'h0,    8'h24, 8'h00, 16'h0280));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 8'h00, l5,              8'h00, 8'h00, 0, 16'h0,    8'h00, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h82, 8'h00, mkid(1, 3, 7, 4), 8'h00, 8'h00, 0, 16'h0,    8'h80, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h02, 8'h00, mkid(1, 3, 7, 4), 8'h00, 8'h00, 0, 16'h0,    8'h02, 8'h00, 16'h0010));
    tbl.push_back(mk(0, 8'h00, 8'h00, 8'h00, 8'h00, l5,              8'h00, 8'h00, 0, 16'h0,    8'h00, 8'h00, 16'h0018));
    for (int r = 0; r < tbl.size(); r++) begin
      reset = tbl[r].rst; req = tbl[r].req; we = tbl[r].we;
      lock_req = tbl[r].lreq; unlock_req = tbl[r].ureq; lock_id = tbl[r].lid;
      @(negedge clk);
      check($sformatf("row%0d gnt", r), 64'(gnt), 64'(tbl[r].gnt));
      check($sformatf("row%0d rvalid", r), 64'(rvalid), 64'(tbl[r].rv));
      check($sformatf("row%0d mem_we", r), 64'(mem_we), 64'(tbl[r].mwe));
      check($sformatf("row%0d lock_ac", r), 64'(lock_ac), 64'(tbl[r].ac));
      check($sformatf("row%0d lock_err", r), 64'(lock_err), 64'(tbl[r].err));
      check($sformatf("row%0d lock_state", r), 64'(lock_state), 64'(tbl[r].st));
      if (tbl[r].gnt != 0) check($sformatf("row%0d mem_adr", r), 64'(mem_adr), 64'h10);
      if (tbl[r].mwe) begin
        ew = '0;
        for (int k = 0; k < C; k++) if (tbl[r].gnt[k]) ew = 16'hBEE9 + 16'(k);
        check($sformatf("row%0d mem_wdat", r), 64'(mem_wdat), 64'(ew));
      end
      if (tbl[r].rv != 0) check($sformatf("row%0d rdat", r), 64'(rdat), 64'(tbl[r].rdat));
      tick();
    end
  endtask

  task automatic run_fair_and_reset();
    logic [C-1:0] eg;
    reset = 1'b1; req = '0; we = '0; lock_req = '0; unlock_req = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < C; i++) adr[i*AW +: AW] = 16'h0080 + 16'(i);
    req = '1;
    for (int n = 0; n < 2 * C; n++) begin
      @(negedge clk);
      eg = '0; eg[n % C] = 1'b1;
      check($sformatf("fair%0d gnt", n), 64'(gnt), 64'(eg));
      eg = '0;
      if (n > 0) eg[(n - 1) % C] = 1'b1;
      check($sformatf("fair%0d rvalid", n), 64'(rvalid), 64'(eg));
      if (n > 0) check($sformatf("fair%0d rdat", n), 64'(rdat), 64'(16'hA080 + 16'((n - 1) % C)));
      tick();
    end
    // Read granted to core 5, then reset lands on the cycle its data would return.
    req = 8'h20; lock_req = 8'h04; lock_id = mkid(2, 1, 2, 1);
    @(negedge clk);
    check("mid gnt", 64'(gnt), 64'h20);
    check("mid rvalid", 64'(rvalid), 64'h80);
    check("mid lock_ac", 64'(lock_ac), 64'h04);
    tick();
    reset = 1'b1; req = 8'h30; we = 8'h10; lock_req = '0;
    @(negedge clk);
    check("rst gnt", 64'(gnt), 64'h0);
    check("rst rvalid", 64'(rvalid), 64'h0);
    check("rst mem_we", 64'(mem_we), 64'h0);
    check("rst lock_state", 64'(lock_state), 64'h0);
    tick();
    reset = 1'b0; req = 8'h50; we = '0; lock_req = 8'h42; lock_id = mkid(1, 2, 6, 3);
    @(negedge clk);
    check("post gnt", 64'(gnt), 64'h10);
    check("post rvalid", 64'(rvalid), 64'h0);
    check("post lock_ac", 64'(lock_ac), 64'h02);
    check("post lock_state", 64'(lock_state), 64'h0);
    tick();
    req = '0; lock_req = '0;
    @(negedge clk);
    check("post2 rvalid", 64'(rvalid), 64'h10);
    check("post2 rdat", 64'(rdat), 64'hA084);
    check("post2 lock_state", 64'(lock_state), 64'h0004);
    tick();
  endtask

  // Randomized run against a behavioural model of the arbitration and mutex rules.
  task automatic run_random(input int n);
    logic [DW-1:0] mmem [256];
    int m_rrm, m_rrl, m_pend;
    logic [DW-1:0] m_pend_data;
    bit m_held [NL];
    int m_owner [NL];
    bit clr [NL];
    logic [C-1:0] r_req, r_we, e_gnt, e_rv, e_ac, e_err;
    logic [NL-1:0] e_st;
    int w, lw, id, c, a;
    for (int k = 0; k < 256; k++) mmem[k] = 16'hA000 + 16'(k);
    m_rrm = 0; m_rrl = 0; m_pend = -1; m_pend_data = '0;
    for (int k = 0; k < NL; k++) begin m_held[k] = 0; m_owner[k] = 0; end
    r_req = '0; r_we = '0;
    for (int t = 0; t < n; t++) begin
      reset = (t < 2) || ($urandom_range(0, 199) == 0);
      for (int i = 0; i < C; i++) begin
        if (!r_req[i] && $urandom_range(0, 1) == 1) begin
          r_req[i] = 1'b1;
          r_we[i]  = 1'($urandom_range(0, 1));
          adr[i*AW +: AW]  = 16'h0080 + 16'($urandom_range(0, 127));
          wdat[i*DW +: DW] = 16'($urandom);
        end
        lock_req[i]   = ($urandom_range(0, 2) == 0);
        unlock_req[i] = ($urandom_range(0, 4) == 0);
        lock_id[i*LW +: LW] = LW'($urandom_range(0, 3));
        if (unlock_req[i] && $urandom_range(0, 1) == 1)
          for (int k = 0; k < 4; k++) if (m_held[k] && m_owner[k] == i) lock_id[i*LW +: LW] = LW'(k);
      end
      req = r_req; we = r_we;
      e_gnt = '0; e_rv = '0; e_ac = '0; e_err = '0; e_st = '0; w = -1; lw = -1;
      for (int k = 0; k < NL; k++) clr[k] = 0;
      if (!reset) begin
        for (int k = 0; k < C; k++) begin
          c = (m_rrm + k) % C;
          if (w < 0 && req[c]) w = c;
        end
        if (w >= 0) e_gnt[w] = 1'b1;
        if (m_pend >= 0) e_rv[m_pend] = 1'b1;
        for (int i = 0; i < C; i++) begin
          id = int'(lock_id[i*LW +: LW]);
          if (unlock_req[i]) begin
            e_ac[i] = 1'b1;
            if (m_held[id] && m_owner[id] == i) clr[id] = 1;
            else e_err[i] = 1'b1;
          end
        end
        for (int k = 0; k < C; k++) begin
          c = (m_rrl + k) % C;
          id = int'(lock_id[c*LW +: LW]);
          if (lw < 0 && lock_req[c] && !unlock_req[c] && !m_held[id]) lw = c;
        end
        if (lw >= 0) e_ac[lw] = 1'b1;
        for (int k = 0; k < NL; k++) e_st[k] = m_held[k];
      end
      @(negedge clk);
      check($sformatf("rnd%0d gnt", t), 64'(gnt), 64'(e_gnt));
      check($sformatf("rnd%0d mem_we", t), 64'(mem_we), 64'((w >= 0) && we[w]));
      check($sformatf("rnd%0d rvalid", t), 64'(rvalid), 64'(e_rv));
      check($sformatf("rnd%0d lock_ac", t), 64'(lock_ac), 64'(e_ac));
      check($sformatf("rnd%0d lock_err", t), 64'(lock_err), 64'(e_err));
      check($sformatf("rnd%0d lock_state", t), 64'(lock_state), 64'(e_st));
      if (w >= 0) check($sformatf("rnd%0d mem_adr", t), 64'(mem_adr), 64'(adr[w*AW +: AW]));
      if (w >= 0 && we[w]) check($sformatf("rnd%0d mem_wdat", t), 64'(mem_wdat), 64'(wdat[w*DW +: DW]));
      if (e_rv != 0) check($sformatf("rnd%0d rdat", t), 64'(rdat), 64'(m_pend_data));
      if (reset) begin
        m_rrm = 0; m_rrl = 0; m_pend = -1;
        for (int k = 0; k < NL; k++) begin m_held[k] = 0; m_owner[k] = 0; end
      end else begin
        m_pend = -1;
        if (w >= 0) begin
          m_rrm = (w + 1) % C;
          a = int'(adr[w*AW +: 8]);
          if (we[w]) mmem[a] = wdat[w*DW +: DW];
          else begin m_pend = w; m_pend_data = mmem[a]; end
          r_req[w] = 1'b0;
        end
        for (int k = 0; k < NL; k++) if (clr[k]) m_held[k] = 0;
        if (lw >= 0) begin
          id = int'(lock_id[lw*LW +: LW]);
          m_held[id] = 1; m_owner[id] = lw; m_rrl = (lw + 1) % C;
        end
      end
      tick();
    end
  endtask

  initial begin
    run_table();
    run_fair_and_reset();
    run_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Shared-memory arbiter for a C-core array: one single-ported data memory serves all cores.
- Provides one memory access per cycle, granted round-robin, instead of a free-running counter slot.
- Includes an NL-entry mutex table with owner tracking and a flagged ack on illegal unlocks.
- Sits between the per-core load/store units and the external data memory macro; memory read latency is 1 cycle.

Parameters:
- C, 8, number of cores/requesters (2..16)
- AW, 16, address width
- DW, 16, data width
- NL, 16, number of mutexes (power of 2)
- LW, $clog2(NL), mutex index width
- CW, $clog2(C), core index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  C  per-core memory access request; held until gnt
- we  in  C  per-core write-enable qualifier (1=write, 0=read)
- adr  in  C*AW  per-core address, core i at [i*AW +: AW]
- wdat  in  C*DW  per-core write data
- gnt  out  C  one-hot combinational grant
- rvalid  out  C  one-hot; read data valid for core i
- rdat  out  DW  read data, broadcast to all cores
- mem_adr  out  AW  memory address
- mem_wdat  out  DW  memory write data
- mem_we  out  1  memory write strobe
- mem_rdat  in  DW  memory read data, valid 1 cycle after address
- lock_req  in  C  per-core try-lock request
- unlock_req  in  C  per-core unlock request
- lock_id  in  C*LW  per-core mutex index
- lock_ac  out  C  combinational ack for lock or unlock
- lock_err  out  C  combinational; with lock_ac, unlock was illegal
- lock_state  out  NL  current mutex held bits (debug/status)

Behaviour:

Reset:
- gnt, rvalid, lock_ac, lock_err, mem_we = 0 while reset is high.
- rr_mem and rr_lock pointers = 0.
- All mutexes free; owners = 0; lock_state = 0.

Memory arbitration:
- The winner is the first requesting core at or after rr_mem, searching upward modulo C.
- gnt[winner] = 1 in the same cycle.
- mem_adr, mem_wdat, and mem_we = we[winner] are driven from the winner; all are 0/don't-care when no request (mem_we = 0).
- At the edge after a grant, rr_mem becomes (winner+1) mod C. With no request, rr_mem holds.
- Read grant to core k in cycle t: rvalid[k] = 1 in cycle t+1, and rdat = mem_rdat in that cycle.
- Write grant: no rvalid.
- Back-to-back grants are allowed; each rvalid tracks its own grant via a registered grant id.
- Fairness: with all C cores requesting continuously, each core is granted exactly once per C cycles.

Lock table:
- Each mutex has a held bit and an owner (CW bits).
- lock_ac[i] and unlock ack are computed from the current state.
- Lock candidates are cores with lock_req set whose lock_id is free.
  - At most one candidate is granted per cycle, chosen round-robin from rr_lock.
  - lock_ac goes high for that core; at the edge, held is set, owner = core, and rr_lock = winner+1.
- A lock_req on a held mutex is not acked and stays pending (spin).
- Every asserting unlock_req is acked in the same cycle.
  - If held and owner == core: clear at the edge, lock_err = 0.
  - Otherwise (free, or a different owner): lock_err = 1 and no state change.
- A core asserting both lock_req and unlock_req in one cycle: unlock is processed, lock is ignored that cycle.
- Same-cycle unlock and lock of the same id: the lock sees the pre-edge state (held), so it is not acked; it can win on the next cycle.
- Two legal unlocks of different ids in one cycle are both applied.
- reset asserted mid-transaction: the pending rvalid is dropped, locks are cleared, and no mem_we is issued in the reset cycle.

Test Plan:
- Fairness: C=8, all req=1 with reads for 16 cycles -> gnt order 0,1,…,7,0,…,7; each rvalid[k] pulses exactly 1 cycle after gnt[k]; rdat matches mem_rdat.
- Sparse requests: rr_mem=0, cores 6 and 2 request, 6 writes adr=0x0010 wdat=0xBEEF -> cycle 1: gnt=0x04 (read); cycle 2: gnt=0x40, mem_we=1, mem_adr=0x0010, mem_wdat=0xBEEF, no rvalid[6].
- Lock contention: cores 1 and 3 lock id 5 -> only core 1 acked, lock_state[5]=1; core 3 spins; core 1 unlocks id 5 -> acked, lock_err=0; next cycle core 3 acked.
- Illegal unlock: core 4 unlocks id 5 owned by core 3 -> lock_ac[4]=1, lock_err[4]=1, lock_state unchanged; unlock of free id 9 -> lock_err=1.
- Same-cycle unlock/lock: core 3 unlocks id 5 while core 0 locks id 5 -> cycle t: core 0 not acked; t+1: core 0 acked and becomes owner.
- Reset mid-operation: read granted in cycle t, reset high in t+1 -> rvalid=0 in t+1, lock_state=0, rr pointers 0, first grant after reset goes to the lowest requesting core.
